// File: rtl/dr_alm_pipe.sv
// dr_alm_pipe: 3-stage signed multiplier, DR-ALM approximate or exact per op,
// with a full-stall valid/ready stream interface and a delivered-result counter.
module dr_alm_pipe #(
  parameter int DWIDTH      = 16,
  parameter int TRUNC_WIDTH = 7
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DWIDTH-1:0]     i_a,
  input  logic [DWIDTH-1:0]     i_b,
  input  logic                  i_mode,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [2*DWIDTH-1:0]   o_z,
  output logic [15:0]           o_count
);

  localparam int N  = DWIDTH;
  localparam int KW = $clog2(DWIDTH);

  localparam logic [N-2:0] LSB  = (N-1)'(1 << (N-1-TRUNC_WIDTH));
  localparam logic [N-2:0] KEEP = ~((N-1)'((1 << (N-1-TRUNC_WIDTH)) - 1));

  if (DWIDTH < 4 || DWIDTH > 32) begin : g_bad_dwidth
    $error("dr_alm_pipe: DWIDTH out of range 4..32");
  end
  if (TRUNC_WIDTH < 1 || TRUNC_WIDTH > DWIDTH-2) begin : g_bad_trunc
    $error("dr_alm_pipe: TRUNC_WIDTH out of range 1..DWIDTH-2");
  end

  typedef struct packed {
    logic          v;
    logic          sign;
    logic          zero;
    logic          mode;
    logic [KW-1:0] ka;
    logic [KW-1:0] kb;
    logic [N-2:0]  fa;
    logic [N-2:0]  fb;
    logic [N-1:0]  ma;
    logic [N-1:0]  mb;
  } s1_t;

  typedef struct packed {
    logic         v;
    logic         sign;
    logic         zero;
    logic         mode;
    logic [KW:0]  k;
    logic [N-1:0] f;
    logic [N-1:0] ma;
    logic [N-1:0] mb;
  } s2_t;

  function automatic logic [N-1:0] mag_of(input logic [N-1:0] x);
    return x[N-1] ? -x : x;
  endfunction

  function automatic logic [KW-1:0] lead_one(input logic [N-1:0] m);
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i < N; i++) begin
      if (m[i]) k = KW'(i);
    end
    return k;
  endfunction

  // Fraction aligned to N-1 fractional bits; long fractions are
  // truncated with the lowest kept bit forced to 1 to centre the error.
  function automatic logic [N-2:0] frac_of(
    input logic [N-1:0]  m,
    input logic [KW-1:0] k
  );
    logic [N-2:0] f;
    f = (N-1)'(m << (KW'(N-1) - k));
    if (int'(k) > TRUNC_WIDTH) f = (f & KEEP) | LSB;
    return f;
  endfunction

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;

  logic           v3_q, v3_d;
  logic [2*N-1:0] z_q, z_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           en;

  logic [N-1:0]   ma_in, mb_in;
  logic [N-1:0]   mant;
  logic [KW+1:0]  e;
  logic [2*N-1:0] p_apx, p_ex, mag, z_nxt;

  assign en      = !v3_q || i_ready;
  assign o_ready = en;
  assign o_valid = v3_q;
  assign o_z     = z_q;
  assign o_count = cnt_q;

  assign ma_in = mag_of(i_a);
  assign mb_in = mag_of(i_b);

  // Antilog: F >= 1 doubles the scale and uses F itself as mantissa.
  always_comb begin
    mant  = s2_q.f[N-1] ? s2_q.f : {1'b1, s2_q.f[N-2:0]};
    e     = (KW+2)'(s2_q.k) + (KW+2)'(s2_q.f[N-1]);
    p_apx = (2*N)'(((3*N)'(mant) << e) >> (N-1));
    p_ex  = (2*N)'(s2_q.ma) * (2*N)'(s2_q.mb);
    mag   = s2_q.zero ? '0 : (s2_q.mode ? p_ex : p_apx);
    z_nxt = s2_q.sign ? -mag : mag;
  end

  always_comb begin
    s1_d  = s1_q;
    s2_d  = s2_q;
    v3_d  = v3_q;
    z_d   = z_q;
    cnt_d = cnt_q + 16'(v3_q && i_ready);
    if (en) begin
      s1_d.v    = i_valid;
      s1_d.sign = i_a[N-1] ^ i_b[N-1];
      s1_d.zero = (i_a == '0) || (i_b == '0);
      s1_d.mode = i_mode;
      s1_d.ka   = lead_one(ma_in);
      s1_d.kb   = lead_one(mb_in);
      s1_d.fa   = frac_of(ma_in, lead_one(ma_in));
      s1_d.fb   = frac_of(mb_in, lead_one(mb_in));
      s1_d.ma   = ma_in;
      s1_d.mb   = mb_in;

      s2_d.v    = s1_q.v;
      s2_d.sign = s1_q.sign;
      s2_d.zero = s1_q.zero;
      s2_d.mode = s1_q.mode;
      s2_d.k    = (KW+1)'(s1_q.ka) + (KW+1)'(s1_q.kb);
      s2_d.f    = N'(s1_q.fa) + N'(s1_q.fb);
      s2_d.ma   = s1_q.ma;
      s2_d.mb   = s1_q.mb;

      v3_d = s2_q.v;
      z_d  = z_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      v3_q  <= 1'b0;
      z_q   <= '0;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      v3_q  <= v3_d;
      z_q   <= z_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dr_alm_pipe.sv
// tb_dr_alm_pipe: directed checks of dr_alm_pipe at DWIDTH=16, TRUNC_WIDTH=7.
// Expected values are hand-computed DR-ALM / exact products.
module tb_dr_alm_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_mode, i_ready;
  logic [15:0] i_a, i_b;
  logic        o_ready, o_valid;
  logic [31:0] o_z;
  logic [15:0] o_count;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  int     ta[13] = '{3, 3, -4, 0, 0, -32768, -32768, 7, 7, 300, 255, -3, -32768};
  int     tb[13] = '{3, 3, 5, -32768, -32768, -32768, -32768, -6, -6, 1, 2, 5, 1};
  logic   tm[13] = '{0, 1, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0};
  longint te[13] = '{8, 9, -20, 0, 0, 1090519040, 1073741824,
                     -40, -42, 302, 510, -14, -33024};

  int     sa[3] = '{10, 12, -14};
  int     sb[3] = '{11, 13, 15};
  longint se[3] = '{110, 156, -210};

  always #5 clk = ~clk;

  dr_alm_pipe #(.DWIDTH(16), .TRUNC_WIDTH(7)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_mode  (i_mode),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_z     (o_z),
    .o_count (o_count)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run1(input int a, input int b, input logic m,
                      input longint exp, input int idx);
    i_a = 16'(a); i_b = 16'(b); i_mode = m;
    i_valid = 1'b1; i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    chk($sformatf("single%0d_early", idx), o_valid, 0);
    tick();
    chk($sformatf("single%0d_valid", idx), o_valid, 1);
    chk($sformatf("single%0d_z", idx), $signed(o_z), exp);
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_mode = 1'b0; i_ready = 1'b0;
    i_a = '0; i_b = '0;
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_z", o_z, 0);
    chk("rst_count", o_count, 0);
    chk("rst_ready", o_ready, 1);
    tick(); tick();
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run1(ta[i], tb[i], tm[i], te[i], i);
    tick();
    chk("single_count", o_count, 13);
    chk("single_drained", o_valid, 0);

    // stall: three pairs fill the pipe, then i_ready stays low
    for (int c = 0; c < 6; c++) begin
      i_valid = 1'b1; i_ready = 1'b0; i_mode = 1'b1;
      i_a = 16'(c < 3 ? sa[c] : 99);
      i_b = 16'(c < 3 ? sb[c] : 99);
      #1;
      chk($sformatf("stall_ready%0d", c), o_ready, (c < 3) ? 1 : 0);
      if (c >= 3) begin
        chk($sformatf("stall_valid%0d", c), o_valid, 1);
        chk($sformatf("stall_z%0d", c), $signed(o_z), se[0]);
      end
      tick();
    end
    i_valid = 1'b0; i_ready = 1'b1;
    for (int d = 0; d < 3; d++) begin
      tick();
      chk($sformatf("drain_valid%0d", d), o_valid, (d < 2) ? 1 : 0);
      if (d < 2) chk($sformatf("drain_z%0d", d), $signed(o_z), se[d+1]);
    end
    chk("drain_count", o_count, 16);

    // reset with two pairs in flight
    i_ready = 1'b1; i_mode = 1'b1;
    i_a = 16'(20); i_b = 16'(20); i_valid = 1'b1;
    tick();
    i_a = 16'(21); i_b = 16'(21);
    tick();
    i_valid = 1'b0;
    tick();
    chk("flight_valid", o_valid, 1);
    i_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_count", o_count, 0);
    chk("arst_z", o_z, 0);
    chk("arst_ready", o_ready, 1);
    tick(); tick();
    rst = 1'b0; i_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("post_rst_valid%0d", c), o_valid, 0);
    end

    // back-to-back stream of 10 exact products
    for (int c = 0; c < 13; c++) begin
      if (c < 10) begin
        i_valid = 1'b1; i_mode = 1'b1;
        i_a = 16'(c + 1); i_b = 16'(c + 2);
      end else begin
        i_valid = 1'b0;
      end
      tick();
      chk($sformatf("stream_valid%0d", c), o_valid, (c >= 2 && c <= 11) ? 1 : 0);
      if (c >= 2 && c <= 11)
        chk($sformatf("stream_z%0d", c), $signed(o_z), longint'((c - 1) * c));
    end
    chk("stream_count", o_count, 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
